hazard_scheduler: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS datapath. It sits beside the decode stage and reads its register addresses and control outputs, plus EX/MEM pipeline-register fields. It sequences stalls (PC/IF-ID hold, ID-EX bubble) and flushes for load-use hazards, jump-register dependencies, multi-cycle multiply/divide occupancy and taken branches.

---
 rtl/hazard_scheduler_if.sv | 60 ++++++
 rtl/hazard_scheduler.sv | 149 ++++++++++++++
 tb/tb_hazard_scheduler.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// ----------------------------------------------------------------------------
// hazard_scheduler_if
//   Groups the decode, EX and MEM fields and the stall/flush controls that are
//   exchanged between the MIPS datapath and hazard_scheduler.
//
//   Datapath -> scheduler : ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_JReg, ID_Jump,
//                           ID_MultStart, ID_UseHiLo, EX_MemRead, EX_RegWrite,
//                           EX_Rd, MEM_MemRead, MEM_Rd, MEM_BranchTaken
//   Scheduler -> datapath : PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
//                           EXMEM_Flush, MulBusy, dbg_state (FSM state, 1=JR_WAIT)
//
//   Handshake: PCWrite/IFID_Write act as the "ready" of the fetch and decode
//   stages. An instruction in ID advances only in a cycle where IFID_Write=1
//   and IDEX_Bubble=0; when IDEX_Bubble=1 whatever enters ID/EX is a no-op.
//
//   slave  : the scheduler side
//   master : the datapath / testbench side
// ----------------------------------------------------------------------------
interface hazard_scheduler_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] ID_Rs;
   logic [REG_ADDR_W-1:0] ID_Rt;
   logic                  ID_UseRs;
   logic                  ID_UseRt;
   logic                  ID_JReg;
   logic                  ID_Jump;
   logic                  ID_MultStart;
   logic                  ID_UseHiLo;
   logic                  EX_MemRead;
   logic                  EX_RegWrite;
   logic [REG_ADDR_W-1:0] EX_Rd;
   logic                  MEM_MemRead;
   logic [REG_ADDR_W-1:0] MEM_Rd;
   logic                  MEM_BranchTaken;

   logic                  PCWrite;
   logic                  IFID_Write;
   logic                  IFID_Flush;
   logic                  IDEX_Bubble;
   logic                  EXMEM_Flush;
   logic                  MulBusy;
   logic                  dbg_state;

   modport slave (
      input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_JReg, ID_Jump,
             ID_MultStart, ID_UseHiLo, EX_MemRead, EX_RegWrite, EX_Rd,
             MEM_MemRead, MEM_Rd, MEM_BranchTaken,
      output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush,
             MulBusy, dbg_state
   );

   modport master (
      output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_JReg, ID_Jump,
             ID_MultStart, ID_UseHiLo, EX_MemRead, EX_RegWrite, EX_Rd,
             MEM_MemRead, MEM_Rd, MEM_BranchTaken,
      input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush,
             MulBusy, dbg_state
   );
endinterface

// File: rtl/hazard_scheduler.sv
// ----------------------------------------------------------------------------
// hazard_scheduler
//   Hazard controller for the 5-stage MIPS pipeline. Sequences stalls
//   (PC/IF-ID hold plus ID-EX bubble) and flushes for load-use hazards,
//   jr/jalr register dependencies, HI/LO multiply/divide occupancy and taken
//   branches. Outputs are Mealy: derived from registered state/counters and
//   the current decode/EX/MEM fields.
//
//   Ports:
//     Clk : pipeline clock, rising edge
//     Rst : asynchronous active-low reset; all controls read 0 while asserted
//     hz  : hazard_scheduler_if.slave (decode/EX/MEM fields in, controls out)
//
//   Priority: taken branch > any stall > jump flush.
// ----------------------------------------------------------------------------
module hazard_scheduler #(
   parameter int MULT_LATENCY = 4,
   parameter int REG_ADDR_W   = 5
) (
   input  logic              Clk,
   input  logic              Rst,
   hazard_scheduler_if.slave hz
);

   localparam int BUSY_W = $clog2(MULT_LATENCY + 1);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_JR_WAIT = 1'b1
   } state_e;

   state_e            state_q,    state_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic              jr_cnt_q,   jr_cnt_d;

   // ------------------------------------------------------------------------
   // Hazard detection terms
   // ------------------------------------------------------------------------
   logic ex_rd_nz;
   logic mem_rd_nz;
   logic load_use;
   logic jr_ex;
   logic jr_mem;
   logic mul_busy;
   logic mul_stall;
   logic jr_wait_stall;
   logic stall;
   logic branch;
   logic mul_issue;

   always_comb begin
      ex_rd_nz  = (hz.EX_Rd  != '0);
      mem_rd_nz = (hz.MEM_Rd != '0);

      load_use  = hz.EX_MemRead && ex_rd_nz &&
                  ((hz.ID_UseRs && (hz.EX_Rd == hz.ID_Rs)) ||
                   (hz.ID_UseRt && (hz.EX_Rd == hz.ID_Rt)));

      // jr/jalr consume rs in decode, so a result still in EX is not forwardable
      jr_ex     = hz.ID_JReg && hz.EX_RegWrite && ex_rd_nz &&
                  (hz.EX_Rd == hz.ID_Rs);

      // a load one stage further on still has its data only at the end of MEM
      jr_mem    = hz.ID_JReg && hz.MEM_MemRead && mem_rd_nz &&
                  (hz.MEM_Rd == hz.ID_Rs);

      mul_busy  = (busy_cnt_q != '0);
      mul_stall = mul_busy && (hz.ID_UseHiLo || hz.ID_MultStart);

      jr_wait_stall = (state_q == ST_JR_WAIT) && (jr_cnt_q != 1'b0);

      stall  = load_use || jr_ex || jr_mem || mul_stall || jr_wait_stall;
      branch = hz.MEM_BranchTaken;

      // the instruction in ID is bubbled on a branch, so it never issues then
      mul_issue = hz.ID_MultStart && !mul_busy && !stall && !branch;
   end

   // ------------------------------------------------------------------------
   // Next-state / counter logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      jr_cnt_d   = jr_cnt_q;
      busy_cnt_d = mul_busy ? (busy_cnt_q - 1'b1) : '0;

      if (branch) begin
         // younger jr is squashed; the older multiply keeps running
         state_d  = ST_RUN;
         jr_cnt_d = 1'b0;
      end else if (state_q == ST_JR_WAIT) begin
         if (jr_cnt_q != 1'b0) begin
            jr_cnt_d = jr_cnt_q - 1'b1;
         end
         // jr_cnt_q is one bit: after this cycle it is always zero
         state_d = ST_RUN;
      end else if (jr_ex && hz.EX_MemRead) begin
         // load feeding jr: one stall now plus one more in JR_WAIT
         state_d  = ST_JR_WAIT;
         jr_cnt_d = 1'b1;
      end

      if (mul_issue) begin
         busy_cnt_d = BUSY_W'(MULT_LATENCY);
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= ST_RUN;
         busy_cnt_q <= '0;
         jr_cnt_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_cnt_q <= busy_cnt_d;
         jr_cnt_q   <= jr_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Control outputs
   // ------------------------------------------------------------------------
   always_comb begin
      hz.PCWrite     = 1'b1;
      hz.IFID_Write  = 1'b1;
      hz.IFID_Flush  = 1'b0;
      hz.IDEX_Bubble = 1'b0;
      hz.EXMEM_Flush = 1'b0;
      hz.MulBusy     = mul_busy;
      hz.dbg_state   = state_q;

      if (!Rst) begin
         hz.PCWrite    = 1'b0;
         hz.IFID_Write = 1'b0;
         hz.MulBusy    = 1'b0;
      end else if (branch) begin
         hz.IFID_Flush  = 1'b1;
         hz.IDEX_Bubble = 1'b1;
         hz.EXMEM_Flush = 1'b1;
      end else if (stall) begin
         hz.PCWrite     = 1'b0;
         hz.IFID_Write  = 1'b0;
         hz.IDEX_Bubble = 1'b1;
      end else if (hz.ID_Jump) begin
         hz.IFID_Flush = 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scheduler.sv
// ----------------------------------------------------------------------------
// tb_hazard_scheduler
//   Directed bench for hazard_scheduler (MULT_LATENCY=4). Inputs are driven
//   1 time unit after each rising edge and outputs are compared 1 unit later.
//   Output vector order: {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
//   EXMEM_Flush, MulBusy}.
// ----------------------------------------------------------------------------
module tb_hazard_scheduler;

   localparam logic [5:0] O_RST   = 6'b000000;
   localparam logic [5:0] O_DEF   = 6'b110000;
   localparam logic [5:0] O_STALL = 6'b000100;
   localparam logic [5:0] O_BR    = 6'b111110;
   localparam logic [5:0] O_JMP   = 6'b111000;
   localparam logic [5:0] O_MB    = 6'b000001;

   logic Clk;
   logic Rst;
   int   total;
   int   bad;
   logic [5:0] got;

   hazard_scheduler_if #(.REG_ADDR_W(5)) hz ();

   hazard_scheduler #(.MULT_LATENCY(4), .REG_ADDR_W(5)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .hz  (hz)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [5:0] outs();
      return {hz.PCWrite, hz.IFID_Write, hz.IFID_Flush, hz.IDEX_Bubble,
              hz.EXMEM_Flush, hz.MulBusy};
   endfunction

   // driver tasks
   task automatic clear_inputs();
      hz.ID_Rs = '0; hz.ID_Rt = '0; hz.ID_UseRs = 1'b0; hz.ID_UseRt = 1'b0;
      hz.ID_JReg = 1'b0; hz.ID_Jump = 1'b0; hz.ID_MultStart = 1'b0;
      hz.ID_UseHiLo = 1'b0; hz.EX_MemRead = 1'b0; hz.EX_RegWrite = 1'b0;
      hz.EX_Rd = '0; hz.MEM_MemRead = 1'b0; hz.MEM_Rd = '0;
      hz.MEM_BranchTaken = 1'b0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
      got = outs();
      total++;
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      clear_inputs();
      hz.ID_Jump = 1'b1;
      hz.ID_MultStart = 1'b1;
      tick();
      settle();
      if (got !== O_RST) begin $display("FAIL reset_outs got=%b exp=%b", got, O_RST); bad++; end
      total++;
      if (hz.dbg_state !== 1'b0) begin $display("FAIL reset_state got=%b exp=0", hz.dbg_state); bad++; end
      tick();
      Rst = 1'b1;
      clear_inputs();
      settle();
      if (got !== O_DEF) begin $display("FAIL post_reset got=%b exp=%b", got, O_DEF); bad++; end
   endtask

   task automatic test_load_use();
      tick();
      clear_inputs();
      hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd5; hz.ID_Rs = 5'd5; hz.ID_UseRs = 1'b1;
      settle();
      if (got !== O_STALL) begin $display("FAIL lu_rs_stall got=%b exp=%b", got, O_STALL); bad++; end
      tick();
      // load has moved to MEM, bubble in EX
      clear_inputs();
      hz.MEM_MemRead = 1'b1; hz.MEM_Rd = 5'd5; hz.ID_Rs = 5'd5; hz.ID_UseRs = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL lu_release got=%b exp=%b", got, O_DEF); bad++; end
      tick();
      clear_inputs();
      hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd0; hz.ID_Rs = 5'd0; hz.ID_UseRs = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL lu_r0 got=%b exp=%b", got, O_DEF); bad++; end
      tick();
      clear_inputs();
      hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd7; hz.ID_Rt = 5'd7; hz.ID_UseRt = 1'b1;
      settle();
      if (got !== O_STALL) begin $display("FAIL lu_rt_stall got=%b exp=%b", got, O_STALL); bad++; end
      tick();
      hz.ID_UseRt = 1'b0;
      settle();
      if (got !== O_DEF) begin $display("FAIL lu_rt_unused got=%b exp=%b", got, O_DEF); bad++; end
   endtask

   task automatic test_jr();
      // jr $8 with lw $8 in EX: two stall cycles
      tick();
      clear_inputs();
      hz.ID_JReg = 1'b1; hz.ID_Rs = 5'd8; hz.ID_UseRs = 1'b1;
      hz.EX_RegWrite = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd8;
      settle();
      if (got !== O_STALL) begin $display("FAIL jr_ld_c1 got=%b exp=%b", got, O_STALL); bad++; end
      tick();
      hz.EX_RegWrite = 1'b0; hz.EX_MemRead = 1'b0; hz.EX_Rd = 5'd0;
      settle();
      if (got !== O_STALL) begin $display("FAIL jr_ld_c2 got=%b exp=%b", got, O_STALL); bad++; end
      total++;
      if (hz.dbg_state !== 1'b1) begin $display("FAIL jr_wait_state got=%b exp=1", hz.dbg_state); bad++; end
      tick();
      settle();
      if (got !== O_DEF) begin $display("FAIL jr_ld_c3 got=%b exp=%b", got, O_DEF); bad++; end
      // jr $8 with ALU producer in EX: one stall cycle
      tick();
      hz.EX_RegWrite = 1'b1; hz.EX_Rd = 5'd8;
      settle();
      if (got !== O_STALL) begin $display("FAIL jr_alu_c1 got=%b exp=%b", got, O_STALL); bad++; end
      tick();
      hz.EX_RegWrite = 1'b0; hz.EX_Rd = 5'd0;
      settle();
      if (got !== O_DEF) begin $display("FAIL jr_alu_c2 got=%b exp=%b", got, O_DEF); bad++; end
      // jr $8 with lw $8 in MEM
      tick();
      hz.MEM_MemRead = 1'b1; hz.MEM_Rd = 5'd8;
      settle();
      if (got !== O_STALL) begin $display("FAIL jr_mem got=%b exp=%b", got, O_STALL); bad++; end
      tick();
      hz.MEM_Rd = 5'd9;
      settle();
      if (got !== O_DEF) begin $display("FAIL jr_mem_other got=%b exp=%b", got, O_DEF); bad++; end
   endtask

   task automatic test_mult();
      tick();
      clear_inputs();
      hz.ID_MultStart = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL mult_issue got=%b exp=%b", got, O_DEF); bad++; end
      // mfhi right behind the mult waits four cycles
      for (int i = 1; i <= 4; i++) begin
         tick();
         clear_inputs();
         hz.ID_UseHiLo = 1'b1;
         settle();
         if (got !== (O_STALL | O_MB)) begin $display("FAIL mfhi_wait%0d got=%b exp=%b", i, got, O_STALL | O_MB); bad++; end
      end
      tick();
      settle();
      if (got !== O_DEF) begin $display("FAIL mfhi_go got=%b exp=%b", got, O_DEF); bad++; end
      // mult, then an unrelated add, then a second mult while busy
      tick();
      clear_inputs();
      hz.ID_MultStart = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL mult2_issue got=%b exp=%b", got, O_DEF); bad++; end
      tick();
      clear_inputs();
      hz.ID_UseRs = 1'b1; hz.ID_Rs = 5'd3;
      settle();
      if (got !== (O_DEF | O_MB)) begin $display("FAIL add_behind got=%b exp=%b", got, O_DEF | O_MB); bad++; end
      tick();
      clear_inputs();
      hz.ID_MultStart = 1'b1;
      settle();
      if (got !== (O_STALL | O_MB)) begin $display("FAIL mult_busy got=%b exp=%b", got, O_STALL | O_MB); bad++; end
      // counter 2 and 1, then free
      for (int i = 0; i < 2; i++) begin
         tick();
         clear_inputs();
         settle();
         if (got !== (O_DEF | O_MB)) begin $display("FAIL drain%0d got=%b exp=%b", i, got, O_DEF | O_MB); bad++; end
      end
      tick();
      settle();
      if (got !== O_DEF) begin $display("FAIL drained got=%b exp=%b", got, O_DEF); bad++; end
   endtask

   task automatic test_branch();
      tick();
      clear_inputs();
      hz.ID_MultStart = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL br_mult got=%b exp=%b", got, O_DEF); bad++; end
      tick();
      clear_inputs();
      hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd5; hz.ID_Rs = 5'd5; hz.ID_UseRs = 1'b1;
      hz.MEM_BranchTaken = 1'b1;
      settle();
      if (got !== (O_BR | O_MB)) begin $display("FAIL br_over_lu got=%b exp=%b", got, O_BR | O_MB); bad++; end
      // busy count continues 3,2,1 then clears
      for (int i = 0; i < 3; i++) begin
         tick();
         clear_inputs();
         settle();
         if (got !== (O_DEF | O_MB)) begin $display("FAIL br_busy%0d got=%b exp=%b", i, got, O_DEF | O_MB); bad++; end
      end
      tick();
      settle();
      if (got !== O_DEF) begin $display("FAIL br_busy_end got=%b exp=%b", got, O_DEF); bad++; end
   endtask

   task automatic test_jump();
      tick();
      clear_inputs();
      hz.ID_Jump = 1'b1;
      settle();
      if (got !== O_JMP) begin $display("FAIL jump got=%b exp=%b", got, O_JMP); bad++; end
      tick();
      clear_inputs();
      settle();
      if (got !== O_DEF) begin $display("FAIL jump_after got=%b exp=%b", got, O_DEF); bad++; end
      // jump held by a load-use stall, flushed once released
      tick();
      hz.ID_Jump = 1'b1;
      hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd4; hz.ID_Rt = 5'd4; hz.ID_UseRt = 1'b1;
      settle();
      if (got !== O_STALL) begin $display("FAIL jump_stalled got=%b exp=%b", got, O_STALL); bad++; end
      tick();
      hz.EX_MemRead = 1'b0; hz.EX_Rd = 5'd0;
      settle();
      if (got !== O_JMP) begin $display("FAIL jump_released got=%b exp=%b", got, O_JMP); bad++; end
   endtask

   task automatic test_reset_mid();
      tick();
      clear_inputs();
      hz.ID_MultStart = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL rm_mult got=%b exp=%b", got, O_DEF); bad++; end
      tick();
      clear_inputs();
      hz.ID_JReg = 1'b1; hz.ID_Rs = 5'd8;
      hz.EX_RegWrite = 1'b1; hz.EX_MemRead = 1'b1; hz.EX_Rd = 5'd8;
      settle();
      if (got !== (O_STALL | O_MB)) begin $display("FAIL rm_jr got=%b exp=%b", got, O_STALL | O_MB); bad++; end
      tick();
      hz.EX_RegWrite = 1'b0; hz.EX_MemRead = 1'b0; hz.EX_Rd = 5'd0;
      settle();
      if (got !== (O_STALL | O_MB)) begin $display("FAIL rm_wait got=%b exp=%b", got, O_STALL | O_MB); bad++; end
      Rst = 1'b0;
      settle();
      if (got !== O_RST) begin $display("FAIL rm_in_reset got=%b exp=%b", got, O_RST); bad++; end
      total++;
      if (hz.dbg_state !== 1'b0) begin $display("FAIL rm_state got=%b exp=0", hz.dbg_state); bad++; end
      tick();
      Rst = 1'b1;
      clear_inputs();
      hz.ID_UseHiLo = 1'b1;
      settle();
      if (got !== O_DEF) begin $display("FAIL rm_after got=%b exp=%b", got, O_DEF); bad++; end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_load_use();
      test_jr();
      test_mult();
      test_branch();
      test_jump();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
